// File: rtl/uart_fifo_regs_pkg.sv
// Register map, STATUS/CTRL bit positions and TX FSM encoding for the UART register block.
// Definitions only: no logic, no latency, no flow control.
package uart_fifo_regs_pkg;

   localparam logic [2:0] REG_DATA   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_RXCNT  = 3'd2;
   localparam logic [2:0] REG_TXCNT  = 3'd3;
   localparam logic [2:0] REG_CTRL   = 3'd4;
   localparam logic [2:0] REG_CLR    = 3'd5;

   localparam int CTRL_LOOPBACK  = 0;
   localparam int CTRL_RX_IRQ_EN = 1;
   localparam int CTRL_TX_IRQ_EN = 2;
   localparam int CTRL_FLUSH     = 7;

   localparam int CLR_RX_OVF  = 0;
   localparam int CLR_TX_DROP = 1;

   // WAIT_HI gives up on txd_busy after this many cycles (counter value of the last one)
   localparam logic [1:0] WAIT_HI_LAST = 2'd3;

   typedef enum logic [1:0] {
      TX_IDLE    = 2'd0,
      TX_START   = 2'd1,
      TX_WAIT_HI = 2'd2,
      TX_WAIT_LO = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_fifo_regs_sync_fifo.sv
// Register-array synchronous FIFO with combinational head and occupancy level; flush beats push/pop.
// Zero-cycle read of head, one-cycle write; push while full is dropped unless a pop happens in the same cycle.
module uart_fifo_regs_sync_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 8
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  empty,
   output logic                  full
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (level == '0);
   assign full    = level[DEPTH_LOG2];
   assign do_pop  = pop & ~empty;
   // at full a simultaneous pop frees the slot the write lands in
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push && !do_pop)      level <= level + LVL_ONE;
         else if (do_pop && !do_push) level <= level - LVL_ONE;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_fifo_regs.sv
// Z80-mapped UART registers with TX/RX FIFOs, loopback, sticky drop flags and registered active-low IRQ.
// Reads are combinational; writes commit one cycle after wr_n falls; full FIFOs drop bytes and raise a sticky flag.
module uart_fifo_regs
   import uart_fifo_regs_pkg::*;
#(
   parameter int         TX_DEPTH_LOG2 = 4,
   parameter int         RX_DEPTH_LOG2 = 4,
   parameter logic [7:0] CTRL_RESET    = 8'h00
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       cs,
   input  logic [2:0] cpu_addr,
   input  logic [7:0] cpu_dout,
   output logic [7:0] cpu_din,
   input  logic       cpu_rd_n,
   input  logic       cpu_wr_n,
   input  logic       cpu_mreq_n,
   output logic       txd_start,
   output logic [7:0] txd_data,
   input  logic       txd_busy,
   input  logic       rxd_data_ready,
   input  logic [7:0] rxd_data,
   output logic       irq_n
);

   logic                   wr_n_q;
   logic                   rd_n_q;
   logic                   pop_pend;
   logic                   wr_commit;
   logic                   rd_fall;
   logic                   rd_rise;
   logic [7:0]             ctrl_q;
   logic                   rx_ovf;
   logic                   tx_drop;
   logic                   irq_q;
   logic                   irq;
   logic                   loopback;
   logic                   flush;

   tx_state_t              state;
   tx_state_t              state_nxt;
   logic [1:0]             wait_cnt;
   logic                   start_req;
   logic                   lb_push;
   logic                   tx_active;

   logic                   tx_push;
   logic                   tx_pop;
   logic [7:0]             tx_head;
   logic [TX_DEPTH_LOG2:0] tx_level;
   logic                   tx_empty;
   logic                   tx_full;

   logic                   rx_push;
   logic                   rx_pop;
   logic [7:0]             rx_din;
   logic [7:0]             rx_head;
   logic [RX_DEPTH_LOG2:0] rx_level;
   logic                   rx_empty;
   logic                   rx_full;

   assign wr_commit = cs & ~cpu_mreq_n & wr_n_q & ~cpu_wr_n;
   assign rd_fall   = cs & ~cpu_mreq_n & rd_n_q & ~cpu_rd_n;
   assign rd_rise   = ~rd_n_q & cpu_rd_n;
   assign loopback  = ctrl_q[CTRL_LOOPBACK];
   assign flush     = wr_commit & (cpu_addr == REG_CTRL) & cpu_dout[CTRL_FLUSH];
   assign tx_push   = wr_commit & (cpu_addr == REG_DATA);
   assign rx_push   = lb_push | (rxd_data_ready & ~loopback);
   assign rx_din    = lb_push ? tx_head : rxd_data;
   // popping on the rd_n rising edge keeps the RX head stable for the whole read cycle
   assign rx_pop    = rd_rise & pop_pend;
   assign irq       = (ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty)
                    | (ctrl_q[CTRL_TX_IRQ_EN] & tx_empty & ~tx_active)
                    | rx_ovf;
   assign irq_n     = ~irq_q;

   uart_fifo_regs_sync_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2), .WIDTH(8)) u_tx_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .push    (tx_push),
      .pop     (tx_pop),
      .flush   (flush),
      .din     (cpu_dout),
      .dout    (tx_head),
      .level   (tx_level),
      .empty   (tx_empty),
      .full    (tx_full)
   );

   uart_fifo_regs_sync_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2), .WIDTH(8)) u_rx_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .push    (rx_push),
      .pop     (rx_pop),
      .flush   (flush),
      .din     (rx_din),
      .dout    (rx_head),
      .level   (rx_level),
      .empty   (rx_empty),
      .full    (rx_full)
   );

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_n_q   <= 1'b1;
         rd_n_q   <= 1'b1;
         pop_pend <= 1'b0;
         ctrl_q   <= CTRL_RESET & 8'h7F;
         rx_ovf   <= 1'b0;
         tx_drop  <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         wr_n_q <= cpu_wr_n;
         rd_n_q <= cpu_rd_n;
         irq_q  <= irq;
         if (rd_fall && cpu_addr == REG_DATA && !rx_empty) pop_pend <= 1'b1;
         else if (rd_rise || flush)                         pop_pend <= 1'b0;
         if (wr_commit && cpu_addr == REG_CTRL) ctrl_q <= {1'b0, cpu_dout[6:0]};
         if (wr_commit && cpu_addr == REG_CLR) begin
            if (cpu_dout[CLR_RX_OVF])  rx_ovf  <= 1'b0;
            if (cpu_dout[CLR_TX_DROP]) tx_drop <= 1'b0;
         end
         if (rx_push && rx_full && !rx_pop && !flush) rx_ovf  <= 1'b1;
         if (tx_push && tx_full && !tx_pop && !flush) tx_drop <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state    <= TX_IDLE;
         wait_cnt <= 2'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= (state == TX_WAIT_HI) ? wait_cnt + 2'd1 : 2'd0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         TX_IDLE:    if (!tx_empty && !flush) state_nxt = TX_START;
         TX_START:   state_nxt = loopback ? TX_IDLE : TX_WAIT_HI;
         TX_WAIT_HI: if (txd_busy || wait_cnt == WAIT_HI_LAST) state_nxt = TX_WAIT_LO;
         TX_WAIT_LO: if (!txd_busy) state_nxt = TX_IDLE;
         default:    state_nxt = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_pop    = (state == TX_START);
      lb_push   = tx_pop & loopback;
      start_req = tx_pop & ~loopback;
      tx_active = (state != TX_IDLE);
   end

   // start pulse and data are registered together so txd_data is already valid during the pulse
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         txd_start <= 1'b0;
         txd_data  <= 8'h00;
      end else begin
         txd_start <= start_req;
         if (tx_pop) txd_data <= tx_head;
      end
   end

   always_comb begin
      cpu_din = 8'h00;
      case (cpu_addr)
         REG_DATA:   if (!rx_empty) cpu_din = rx_head;
         REG_STATUS: cpu_din = {irq_q, tx_drop, rx_ovf, tx_full, tx_empty, rx_full, ~rx_empty, tx_active};
         REG_RXCNT:  cpu_din = 8'(rx_level);
         REG_TXCNT:  cpu_din = 8'(tx_level);
         REG_CTRL:   cpu_din = ctrl_q;
         default:    cpu_din = 8'h00;
      endcase
   end

endmodule
